uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: receive side of the APB UART. Synchronises rx_serial, finds
// start bits and recovers DATA_BITS data bits LSB-first by sampling each bit
// at its centre. Each frame gives one rx_valid pulse (good stop bit) or one
// rx_frame_err pulse (stop bit sampled low).
//
// Ports:
//   PCLK         system clock
//   PRESET       synchronous, active-high reset
//   rx_serial    asynchronous serial line, idle high
//   rx_data      last correctly framed byte, held until the next good frame
//   rx_valid     one-cycle pulse when rx_data is updated
//   rx_frame_err one-cycle pulse when the stop bit is sampled low
//   rx_busy      high while a frame is in progress
module uart_receiver #(
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BIT_TICKS    = CLKS_PER_BIT + 1;
  localparam int unsigned HALF         = BIT_TICKS / 2;
  localparam int unsigned CNT_W        = $clog2(BIT_TICKS) + 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t               state, next_state;
  logic                 sync_q1, rx_sync;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d, rx_frame_err_d, rx_busy_d;
  logic                 half_done, bit_done, last_bit;

  // Two-flop synchroniser for the asynchronous line; resets to idle level.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync_q1 <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_q1 <= rx_serial;
      rx_sync <= sync_q1;
    end
  end

  // Counter value one below the target because the counter is cleared on
  // the edge that starts each interval.
  assign half_done = (clk_cnt == CNT_W'(HALF - 1));
  assign bit_done  = (clk_cnt == CNT_W'(BIT_TICKS - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_BITS - 1));

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (!rx_sync) next_state = ST_START;
      ST_START:     if (half_done) next_state = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_done && last_bit) next_state = ST_STOP;
      ST_STOP:      if (bit_done) next_state = rx_sync ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_sync) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    clk_cnt_d      = clk_cnt;
    bit_cnt_d      = bit_cnt;
    shift_d        = shift_q;
    rx_data_d      = rx_data;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_busy_d      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      ST_START: begin
        clk_cnt_d = clk_cnt + CNT_W'(1);
        if (half_done) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        clk_cnt_d = clk_cnt + CNT_W'(1);
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt + BIT_W'(1);
          // LSB-first: new bit enters at the top and moves down.
          shift_d   = (shift_q >> 1) | (DATA_BITS'(rx_sync) << (DATA_BITS - 1));
        end
      end
      ST_STOP: begin
        clk_cnt_d = clk_cnt + CNT_W'(1);
        if (bit_done) begin
          clk_cnt_d = '0;
          if (rx_sync) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_frame_err_d = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        clk_cnt_d = '0;
      end
      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      clk_cnt      <= clk_cnt_d;
      bit_cnt      <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      rx_frame_err <= rx_frame_err_d;
      rx_busy      <= rx_busy_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver at BIT_TICKS=11, HALF=5.
module tb_uart_receiver;

  localparam int BT = 11;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  int errors = 0;
  int checks = 0;

  uart_receiver #(
    .BAUD_RATE(100_000),
    .CLK_FREQ (1_000_000),
    .DATA_BITS(8)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 PCLK = ~PCLK;

  // Pulse monitor: counts high cycles so a stretched pulse shows as >1.
  int         cyc = 0;
  int         valid_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  logic [7:0] vdata_q[$];
  int         vtime_q[$];

  always @(posedge PCLK) cyc++;

  always @(negedge PCLK) begin
    if (rx_valid) begin
      valid_cnt++;
      vdata_q.push_back(rx_data);
      vtime_q.push_back(cyc);
    end
    if (rx_frame_err) ferr_cnt++;
    if (rx_valid && rx_frame_err) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one frame; caller must be at a negedge.
  task automatic send_frame(input logic [7:0] d, input bit stop);
    rx_serial = 1'b0;
    repeat (BT) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (BT) @(negedge PCLK);
    end
    rx_serial = stop;
    repeat (BT) @(negedge PCLK);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge PCLK);
  endtask

  // Reference model: the last byte with a good stop bit is what rx_data shows.
  logic [7:0] model_data = 8'h00;

  // Full frame plus recovery, checked against the model.
  task automatic run_frame(input string tag, input logic [7:0] d, input bit stop, input int low_hold);
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(d, stop);
    if (!stop) repeat (low_hold) @(negedge PCLK);
    idle(20);
    if (stop) model_data = d;
    check({tag, "_valid"}, valid_cnt - v0, stop ? 1 : 0);
    check({tag, "_ferr"},  ferr_cnt - f0,  stop ? 0 : 1);
    check({tag, "_data"},  int'(rx_data), int'(model_data));
    check({tag, "_busy"},  int'(rx_busy), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, q0, lat;
    bit found;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h5A, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // Reset state.
    PRESET    = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge PCLK);
    check("rst_data",  int'(rx_data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_ferr",  int'(rx_frame_err), 0);
    check("rst_busy",  int'(rx_busy), 0);
    PRESET = 1'b0;
    idle(5);

    // Table vectors with hand-derived expectations.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].d, vecs[i].stop);
      if (!vecs[i].stop) repeat (20) @(negedge PCLK);
      idle(20);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i),  ferr_cnt - f0,  vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i),  int'(rx_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy", i),  int'(rx_busy), 0);
    end
    model_data = 8'h81;

    // Glitch shorter than half a bit is rejected.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx_serial = 1'b0;
    repeat (3) @(negedge PCLK);
    rx_serial = 1'b1;
    repeat (8) @(negedge PCLK);
    check("glitch_busy", int'(rx_busy), 0);
    idle(30);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_ferr",  ferr_cnt - f0, 0);
    check("glitch_data",  int'(rx_data), int'(model_data));

    // Good frame, then bad stop bit with the line held low as a break.
    run_frame("brk_pre", 8'hA5, 1'b1, 0);
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (50) @(negedge PCLK);
    check("brk_busy_low", int'(rx_busy), 1);
    check("brk_ferr_once", ferr_cnt - f0, 1);
    check("brk_data", int'(rx_data), 8'hA5);
    idle(10);
    check("brk_busy_after", int'(rx_busy), 0);
    idle(10);

    // Back-to-back frames, no idle gap.
    q0 = vtime_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_count", vtime_q.size() - q0, 2);
    if (vtime_q.size() - q0 == 2) begin
      check("b2b_gap",   vtime_q[q0 + 1] - vtime_q[q0], 110);
      check("b2b_data0", int'(vdata_q[q0]), 8'h00);
      check("b2b_data1", int'(vdata_q[q0 + 1]), 8'hFF);
    end
    model_data = 8'hFF;

    // Reset in the middle of the data bits of 0x5A.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx_serial = 1'b0;
    repeat (BT) @(negedge PCLK);
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h5A >> i) & 1;
      repeat (BT) @(negedge PCLK);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    rx_serial = 1'b1;
    check("mrst_data",  int'(rx_data), 0);
    check("mrst_valid", int'(rx_valid), 0);
    check("mrst_ferr",  int'(rx_frame_err), 0);
    check("mrst_busy",  int'(rx_busy), 0);
    model_data = 8'h00;
    idle(150);
    check("mrst_no_valid", valid_cnt - v0, 0);
    check("mrst_no_ferr",  ferr_cnt - f0, 0);
    run_frame("mrst_post", 8'h81, 1'b1, 0);

    // Latency from first low cycle on rx_serial to rx_valid.
    lat = 0;
    found = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int k = 0; k < 200 && !found; k++) begin
          @(posedge PCLK);
          lat++;
          @(negedge PCLK);
          if (rx_valid) found = 1'b1;
        end
      end
    join
    idle(20);
    check("lat_seen", int'(found), 1);
    check("lat_cycles", lat, 107);
    check("lat_data", int'(rx_data), 8'h55);
    model_data = 8'h55;

    // Random frames against the model.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      bit         s;
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", n), d, s, 5 + $urandom_range(0, 20));
      idle($urandom_range(0, 15));
    end

    check("valid_ferr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
